// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV64 pipeline constants and fetch-stage types
package riscv_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic {
    SKID_RUN  = 1'b0,
    SKID_HOLD = 1'b1
  } skid_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory, control and IF/ID bundle of the fetch stage
interface fetch_stage_if #(
  parameter int XLEN    = 64,
  parameter int IMEM_AW = 10
);

  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;

  logic               stall;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;

  logic               if_id_valid;
  logic [XLEN-1:0]    if_id_pc;
  logic [XLEN-1:0]    if_id_pc_plus4;
  logic [31:0]        if_id_instr;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  stall, redirect_valid, redirect_pc,
    output if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output stall, redirect_valid, redirect_pc,
    input  if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry {pc, instr} store absorbing decode back-pressure
module fetch_skid_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  skid_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A simultaneous drain and load keeps the entry occupied with the new word.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = SKID_RUN;
    end else if (load_i) begin
      state_d = SKID_HOLD;
    end else if (drain_i) begin
      state_d = SKID_RUN;
    end
  end

  always_comb begin
    valid_o = (state_q == SKID_HOLD);
    pc_o    = pc_q;
    instr_o = instr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (load_i && !clear_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV64 instruction fetch: PC, imem requests, redirect and IF/ID register
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              IMEM_AW  = 10,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            rsp_pending_q, rsp_pending_d;

  logic            if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
  logic [31:0]     if_id_instr_q, if_id_instr_d;

  logic            skid_valid, skid_load, skid_drain, skid_clear;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;

  logic [XLEN-1:0] fetch_pc;
  logic            if_id_free;
  logic            imem_req;

  assign fetch_pc   = bus.redirect_valid ? (bus.redirect_pc & ~XLEN'(3)) : pc_q;
  assign if_id_free = !bus.stall || !if_id_valid_q;

  // A redirect always issues its target, even when the skid is occupied.
  assign imem_req = reset &&
                    (bus.redirect_valid ||
                     (!skid_valid && !(bus.stall && rsp_pending_q && if_id_valid_q)));

  assign bus.imem_req       = imem_req;
  assign bus.imem_addr      = fetch_pc[IMEM_AW+1:2];
  assign bus.if_id_valid    = if_id_valid_q;
  assign bus.if_id_pc       = if_id_pc_q;
  assign bus.if_id_pc_plus4 = if_id_pc_plus4_q;
  assign bus.if_id_instr    = if_id_instr_q;

  fetch_skid_buffer #(
    .XLEN (XLEN)
  ) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .clear_i (skid_clear),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .pc_i    (rsp_pc_q),
    .instr_i (bus.imem_rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  always_comb begin
    pc_d             = pc_q;
    rsp_pc_d         = rsp_pc_q;
    rsp_pending_d    = 1'b0;
    if_id_valid_d    = if_id_valid_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus4_d = if_id_pc_plus4_q;
    if_id_instr_d    = if_id_instr_q;
    skid_load        = 1'b0;
    skid_drain       = 1'b0;
    skid_clear       = 1'b0;

    if (imem_req) begin
      pc_d          = fetch_pc + XLEN'(4);
      rsp_pending_d = 1'b1;
      rsp_pc_d      = fetch_pc;
    end

    if (bus.redirect_valid) begin
      skid_clear    = 1'b1;
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
    end else if (rsp_pending_q) begin
      if (if_id_free && skid_valid) begin
        // Older skid word goes first; the fresh response refills the skid.
        if_id_valid_d    = 1'b1;
        if_id_pc_d       = skid_pc;
        if_id_pc_plus4_d = skid_pc + XLEN'(4);
        if_id_instr_d    = skid_instr;
        skid_drain       = 1'b1;
        skid_load        = 1'b1;
      end else if (if_id_free) begin
        if_id_valid_d    = 1'b1;
        if_id_pc_d       = rsp_pc_q;
        if_id_pc_plus4_d = rsp_pc_q + XLEN'(4);
        if_id_instr_d    = bus.imem_rdata;
      end else begin
        skid_load = 1'b1;
      end
    end else if (if_id_free) begin
      if (skid_valid) begin
        if_id_valid_d    = 1'b1;
        if_id_pc_d       = skid_pc;
        if_id_pc_plus4_d = skid_pc + XLEN'(4);
        if_id_instr_d    = skid_instr;
        skid_drain       = 1'b1;
      end else begin
        if_id_valid_d = 1'b0;
        if_id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q             <= RESET_PC;
      rsp_pc_q         <= '0;
      rsp_pending_q    <= 1'b0;
      if_id_valid_q    <= 1'b0;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      if_id_instr_q    <= NOP_INSTR;
    end else begin
      pc_q             <= pc_d;
      rsp_pc_q         <= rsp_pc_d;
      rsp_pending_q    <= rsp_pending_d;
      if_id_valid_q    <= if_id_valid_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus4_q <= if_id_pc_plus4_d;
      if_id_instr_q    <= if_id_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] mem [0:1023];

  fetch_stage_if #(.XLEN(64), .IMEM_AW(10)) bus ();

  fetch_stage #(
    .XLEN     (64),
    .IMEM_AW  (10),
    .RESET_PC (64'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];
  end

  function automatic logic [31:0] exp_word(input logic [63:0] pc);
    logic [9:0] w;
    w = pc[11:2];
    case (w)
      10'd0:   exp_word = 32'h00100093;
      10'd1:   exp_word = 32'h00800113;
      10'd2:   exp_word = 32'h00A00213;
      10'd3:   exp_word = 32'h00000193;
      default: exp_word = 32'hA0000000 | {22'd0, w};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.if_id_valid); end
    checks++; if (bus.if_id_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.if_id_pc); end
    checks++; if (bus.if_id_pc_plus4 !== 64'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", bus.if_id_pc_plus4); end
    checks++; if (bus.if_id_instr !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", bus.if_id_instr, NOP); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
    reset = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd0) begin
      errors++; $display("FAIL first_req got req=%b addr=%0d exp req=1 addr=0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    step();
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL seq_latency got=%b exp=0", bus.if_id_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 64'(4*k) ||
                    bus.if_id_pc_plus4 !== 64'(4*k+4) || bus.if_id_instr !== exp_word(64'(4*k))) begin
        errors++; $display("FAIL seq_%0d got v=%b pc=%h pc4=%h ins=%h exp v=1 pc=%h ins=%h",
                           k, bus.if_id_valid, bus.if_id_pc, bus.if_id_pc_plus4, bus.if_id_instr, 64'(4*k), exp_word(64'(4*k)));
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] got_pc [$];
    logic [31:0] got_in [$];
    apply_reset();
    repeat (3) step();
    bus.stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 64'h4 || bus.if_id_instr !== 32'h00800113) begin
        errors++; $display("FAIL stall_hold_%0d got v=%b pc=%h ins=%h exp v=1 pc=4 ins=00800113",
                           c, bus.if_id_valid, bus.if_id_pc, bus.if_id_instr);
      end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_%0d got=%b exp=0", c, bus.imem_req); end
    end
    bus.stall = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.if_id_valid) begin got_pc.push_back(bus.if_id_pc); got_in.push_back(bus.if_id_instr); end
    end
    checks++;
    if (got_pc.size() < 3) begin
      errors++; $display("FAIL stall_release_count got=%0d exp>=3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (got_pc[i] !== 64'(8 + 4*i) || got_in[i] !== exp_word(64'(8 + 4*i))) begin
          errors++; $display("FAIL stall_release_%0d got pc=%h ins=%h exp pc=%h ins=%h",
                             i, got_pc[i], got_in[i], 64'(8 + 4*i), exp_word(64'(8 + 4*i)));
        end
      end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    repeat (3) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h40;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd16) begin
      errors++; $display("FAIL redir_req got req=%b addr=%0d exp req=1 addr=16", bus.imem_req, bus.imem_addr);
    end
    step();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP) begin
      errors++; $display("FAIL redir_bubble got v=%b ins=%h exp v=0 ins=%h", bus.if_id_valid, bus.if_id_instr, NOP);
    end
    step();
    checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 64'h40 || bus.if_id_pc_plus4 !== 64'h44 || bus.if_id_instr !== 32'hA0000010) begin
      errors++; $display("FAIL redir_target got v=%b pc=%h pc4=%h ins=%h exp v=1 pc=40 pc4=44 ins=a0000010",
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_pc_plus4, bus.if_id_instr);
    end
    step();
    checks++; if (bus.if_id_pc !== 64'h44 || bus.if_id_instr !== 32'hA0000011) begin
      errors++; $display("FAIL redir_next got pc=%h ins=%h exp pc=44 ins=a0000011", bus.if_id_pc, bus.if_id_instr);
    end
  endtask

  task automatic test_redirect_stall();
    logic [63:0] got_pc [$];
    apply_reset();
    repeat (3) step();
    bus.stall = 1'b1;
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h80;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd32) begin
      errors++; $display("FAIL rs_req got req=%b addr=%0d exp req=1 addr=32", bus.imem_req, bus.imem_addr);
    end
    step();
    bus.redirect_valid = 1'b0;
    checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_instr !== NOP) begin
      errors++; $display("FAIL rs_bubble got v=%b ins=%h exp v=0 ins=%h", bus.if_id_valid, bus.if_id_instr, NOP);
    end
    step();
    checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 64'h80 || bus.if_id_instr !== 32'hA0000020) begin
      errors++; $display("FAIL rs_target got v=%b pc=%h ins=%h exp v=1 pc=80 ins=a0000020",
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_instr);
    end
    step();
    checks++; if (bus.if_id_pc !== 64'h80 || bus.if_id_instr !== 32'hA0000020) begin
      errors++; $display("FAIL rs_hold got pc=%h ins=%h exp pc=80 ins=a0000020", bus.if_id_pc, bus.if_id_instr);
    end
    bus.stall = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.if_id_valid) got_pc.push_back(bus.if_id_pc);
    end
    checks++; if (got_pc.size() < 2 || got_pc[0] !== 64'h84 || got_pc[1] !== 64'h88) begin
      errors++; $display("FAIL rs_release got n=%0d first=%h exp first=84 then 88", got_pc.size(),
                         (got_pc.size() > 0) ? got_pc[0] : 64'hx);
    end
  endtask

  task automatic test_misaligned_and_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h43;
    #1;
    checks++; if (bus.imem_addr !== 10'd16) begin errors++; $display("FAIL misalign_addr got=%0d exp=16", bus.imem_addr); end
    step();
    bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.if_id_pc !== 64'h40 || bus.if_id_pc_plus4 !== 64'h44) begin
      errors++; $display("FAIL misalign_pc got pc=%h pc4=%h exp pc=40 pc4=44", bus.if_id_pc, bus.if_id_pc_plus4);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'hFF8;
    #1;
    checks++; if (bus.imem_addr !== 10'd1022) begin errors++; $display("FAIL wrap_addr0 got=%0d exp=1022", bus.imem_addr); end
    step();
    bus.redirect_valid = 1'b0;
    #1;
    checks++; if (bus.imem_addr !== 10'd1023) begin errors++; $display("FAIL wrap_addr1 got=%0d exp=1023", bus.imem_addr); end
    step();
    checks++; if (bus.imem_addr !== 10'd0) begin errors++; $display("FAIL wrap_addr2 got=%0d exp=0", bus.imem_addr); end
    step();
    step();
    checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 64'h1000 || bus.if_id_instr !== 32'h00100093) begin
      errors++; $display("FAIL wrap_ifid got v=%b pc=%h ins=%h exp v=1 pc=1000 ins=00100093",
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_instr);
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    repeat (3) step();
    bus.stall = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    checks++; if (bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 64'h0 || bus.if_id_pc_plus4 !== 64'h0 ||
                  bus.if_id_instr !== NOP || bus.imem_req !== 1'b0) begin
      errors++; $display("FAIL midreset got v=%b pc=%h pc4=%h ins=%h req=%b exp all reset values",
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_pc_plus4, bus.if_id_instr, bus.imem_req);
    end
    bus.stall = 1'b0;
    step();
    #1;
    reset = 1'b1;
    repeat (2) step();
    checks++; if (bus.if_id_valid !== 1'b1 || bus.if_id_pc !== 64'h0 || bus.if_id_instr !== 32'h00100093) begin
      errors++; $display("FAIL midreset_restart got v=%b pc=%h ins=%h exp v=1 pc=0 ins=00100093",
                         bus.if_id_valid, bus.if_id_pc, bus.if_id_instr);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 1024; i++) mem[i] = exp_word(64'(4*i));
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misaligned_and_wrap();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
